// File: rtl/fetch_unit.sv
// fetch_unit
//   Owns the fetch PC, issues in-order pipelined reads to instruction memory
//   over req/gnt/rvalid, buffers returned words with their PCs in a prefetch
//   queue and presents the queue head to the control unit (valid/ready).
//   Redirects (absolute or relative to the head PC) flush the queue and
//   discard responses still in flight.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous reset, active low
//   mem_req         fetch request valid
//   mem_addr        fetch address (current fetch PC)
//   mem_gnt         request accepted this cycle
//   mem_rvalid      response word valid
//   mem_rdata       response word
//   redirect_valid  redirect this cycle
//   redirect_add    1: target = out_pc + redirect_value, 0: target = redirect_value
//   redirect_value  offset or absolute target
//   out_valid       queue head valid
//   out_instr       head instruction
//   out_pc          head PC
//   out_ready       consumer pops head
//   fifo_count      entries held in the queue

module fetch_unit #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          redirect_valid,
  input  logic                          redirect_add,
  input  logic [ADDR_WIDTH-1:0]         redirect_value,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_instr,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [ADDR_WIDTH-1:0] last_pc;
  logic [DATA_WIDTH-1:0] last_instr;
  logic [ADDR_WIDTH-1:0] target;

  logic [DATA_WIDTH-1:0] q_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      inflight_nxt;
  logic [CNT_W-1:0]      discard;
  logic [CNT_W:0]        credit_used;

  logic                  fire;
  logic                  push;
  logic                  pop;

  // Queued entries plus outstanding requests (including ones to be
  // discarded) never exceed the queue depth, so a push always has room.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign mem_req     = rst && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign mem_addr    = fetch_pc;
  assign fire        = mem_req && mem_gnt;

  assign out_valid   = (count != '0);
  // While empty the outputs show the last head that was presented.
  assign out_instr   = out_valid ? q_instr[rd_ptr] : last_instr;
  assign out_pc      = out_valid ? q_pc[rd_ptr]    : last_pc;
  assign fifo_count  = count;

  assign pop          = out_valid && out_ready;
  assign push         = mem_rvalid && (discard == '0);
  assign inflight_nxt = inflight + CNT_W'(fire) - CNT_W'(mem_rvalid);
  assign target       = redirect_add ? (out_pc + redirect_value) : redirect_value;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inflight   <= '0;
      discard    <= '0;
      last_pc    <= '0;
      last_instr <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (out_valid) begin
        last_pc    <= q_pc[rd_ptr];
        last_instr <= q_instr[rd_ptr];
      end
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old
        // stream; a response arriving this cycle is simply not pushed.
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= inflight_nxt;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + STEP;
        end
        if (mem_rvalid && (discard != '0)) begin
          discard <= discard - CNT_W'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + STEP;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (rst && !redirect_valid && push) begin
      q_instr[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Randomized bench for fetch_unit with an in-order memory model and a
//   queue-based reference model of the fetch stream, plus directed scenarios
//   for first-fetch latency, credit limit, PC wrap, redirects and reset.

module tb_fetch_unit;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          redirect_valid;
  logic          redirect_add;
  logic [AW-1:0] redirect_value;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (10'd0),
    .PC_STEP    (4),
    .FIFO_DEPTH (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_add   (redirect_add),
    .redirect_value (redirect_value),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] instr; } ent_t;
  typedef struct { logic [AW-1:0] addr; int due; } pend_t;

  // reference model state
  ent_t          mq[$];
  logic [AW-1:0] m_fetch, m_resp, held_pc;
  logic [DW-1:0] held_instr;
  int            m_inflight, m_discard;
  bit            m_known = 0;

  // memory model
  pend_t pend[$];
  int    cyc = 0;
  int    last_due = 0;

  // delivered heads as seen on the DUT outputs
  ent_t dlog[$];
  int   dcyc[$];
  int   n_fire = 0;

  // stimulus knobs
  int gnt_pct = 100, ready_pct = 100, lat_lo = 1, lat_hi = 1, redir_pct = 0, rst_pm = 0;
  bit force_rst = 0, force_redir = 0, f_add = 0;
  logic [AW-1:0] f_val = '0;

  // snapshots of the last sampled DUT outputs
  logic       s_valid, s_req;
  logic [2:0] s_count;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {a, 22'h15a5a5} ^ (32'h9e37_79b1 * ({22'h0, a} + 32'd1));
  endfunction

  function automatic ent_t dget(input int i);
    ent_t e;
    e.pc = '1;
    e.instr = '1;
    if (i < dlog.size()) e = dlog[i];
    return e;
  endfunction

  task automatic step();
    logic          m_req, fire, rv, pop;
    logic [AW-1:0] cur_pc, tgt;
    logic [DW-1:0] cur_instr;
    pend_t         p;
    int            due;
    @(negedge clk);
    cur_pc    = (mq.size() > 0) ? mq[0].pc    : held_pc;
    cur_instr = (mq.size() > 0) ? mq[0].instr : held_instr;
    if (m_known) begin
      m_req = rst && ((mq.size() + m_inflight) < D);
      check("out_valid",  out_valid,  mq.size() > 0);
      check("fifo_count", fifo_count, mq.size());
      check("mem_req",    mem_req,    m_req);
      check("mem_addr",   mem_addr,   m_fetch);
      check("out_pc",     out_pc,     cur_pc);
      check("out_instr",  out_instr,  cur_instr);
    end
    s_valid = out_valid;
    s_count = fifo_count;
    s_req   = mem_req;

    rst       = !(force_rst || ($urandom_range(0, 999) < rst_pm));
    mem_gnt   = ($urandom_range(0, 99) < gnt_pct);
    out_ready = ($urandom_range(0, 99) < ready_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_add   = f_add;
      redirect_value = f_val;
      force_redir    = 0;
    end else begin
      redirect_valid = ($urandom_range(0, 99) < redir_pct);
      redirect_add   = $urandom_range(0, 1) == 1;
      redirect_value = AW'($urandom);
    end
    rv         = (pend.size() > 0) && (pend[0].due <= cyc);
    mem_rvalid = rv;
    mem_rdata  = rv ? word(pend[0].addr) : $urandom;
    m_req      = rst && ((mq.size() + m_inflight) < D);
    fire       = m_req && mem_gnt;
    pop        = (mq.size() > 0) && out_ready;
    #1;
    if (mem_req && mem_gnt) n_fire++;
    if (rst && out_valid && out_ready) begin
      dlog.push_back('{out_pc, out_instr});
      dcyc.push_back(cyc);
    end

    @(posedge clk);
    if (!rst) begin
      pend.delete();
    end else begin
      if (rv) p = pend.pop_front();
      if (fire) begin
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{m_fetch, due});
      end
    end

    if (!rst) begin
      mq.delete();
      m_fetch    = '0;
      m_resp     = '0;
      held_pc    = '0;
      held_instr = '0;
      m_inflight = 0;
      m_discard  = 0;
      m_known    = 1;
    end else begin
      if (mq.size() > 0) begin
        held_pc    = mq[0].pc;
        held_instr = mq[0].instr;
      end
      if (redirect_valid) begin
        tgt        = redirect_add ? AW'(cur_pc + redirect_value) : redirect_value;
        m_inflight = m_inflight + int'(fire) - int'(rv);
        m_discard  = m_inflight;
        m_fetch    = tgt;
        m_resp     = tgt;
        mq.delete();
      end else begin
        if (fire) begin
          m_inflight++;
          m_fetch = m_fetch + AW'(4);
        end
        if (pop) void'(mq.pop_front());
        if (rv) begin
          m_inflight--;
          if (m_discard > 0) m_discard--;
          else begin
            mq.push_back('{m_resp, mem_rdata});
            m_resp = m_resp + AW'(4);
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    force_rst = 1;
    repeat (3) step();
    force_rst = 0;
  endtask

  task automatic zero_wait();
    gnt_pct = 100; ready_pct = 100; lat_lo = 1; lat_hi = 1; redir_pct = 0; rst_pm = 0;
  endtask

  initial begin
    int   r, k;
    ent_t e;
    rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_add = 1'b0; redirect_value = '0; out_ready = 1'b0;

    // first-fetch latency and sequential stream
    zero_wait();
    do_reset();
    check("rst_count", s_count, 0);
    check("rst_valid", s_valid, 0);
    check("rst_req",   s_req,   0);
    r = cyc;
    dlog.delete(); dcyc.delete();
    repeat (10) step();
    check("p1_n", dlog.size() >= 3, 1);
    if (dcyc.size() >= 3) begin
      check("p1_lat0", dcyc[0] - r, 2);
      check("p1_lat1", dcyc[1] - r, 3);
      check("p1_lat2", dcyc[2] - r, 4);
    end
    check("p1_pc0", dget(0).pc, 0);
    check("p1_pc1", dget(1).pc, 4);
    check("p1_pc2", dget(2).pc, 8);
    check("p1_in2", dget(2).instr, word(10'd8));

    // credit limit with a stalled consumer
    ready_pct = 0;
    do_reset();
    n_fire = 0;
    repeat (12) step();
    check("p2_grants", n_fire, 4);
    check("p2_count",  s_count, 4);
    check("p2_req",    s_req, 0);
    ready_pct = 100;
    step();
    ready_pct = 0;
    n_fire = 0;
    repeat (8) step();
    check("p2_regrant", n_fire, 1);

    // PC wrap at the top of the address space
    zero_wait();
    do_reset();
    force_redir = 1; f_add = 0; f_val = 10'd1020;
    step();
    dlog.delete(); dcyc.delete();
    repeat (10) step();
    check("p3_pc0", dget(0).pc, 1020);
    check("p3_pc1", dget(1).pc, 0);
    check("p3_pc2", dget(2).pc, 4);
    check("p3_in1", dget(1).instr, word(10'd0));

    // absolute redirect with three requests outstanding
    zero_wait();
    lat_lo = 3; lat_hi = 3;
    do_reset();
    k = 0;
    while (m_inflight != 3 && k < 30) begin step(); k++; end
    if (m_inflight != 3) check("p4_wait", m_inflight, 3);
    force_redir = 1; f_add = 0; f_val = 10'd100;
    step();
    dlog.delete(); dcyc.delete();
    step();
    check("p4_flush_count", s_count, 0);
    check("p4_flush_valid", s_valid, 0);
    repeat (12) step();
    check("p4_pc",    dget(0).pc, 100);
    check("p4_instr", dget(0).instr, word(10'd100));

    // relative redirect coinciding with a response and a grant
    zero_wait();
    do_reset();
    force_redir = 1; f_add = 0; f_val = 10'd40;
    step();
    k = 0;
    while (!(mq.size() > 0 && mq[0].pc == 10'd40) && k < 20) begin step(); k++; end
    if (!(mq.size() > 0)) check("p5_wait", mq.size(), 1);
    force_redir = 1; f_add = 1; f_val = 10'h3f8;
    step();
    check("p5_pc_at_redirect", dget(dlog.size() - 1).pc, 40);
    check("p5_req_at_redirect", s_req, 1);
    dlog.delete(); dcyc.delete();
    repeat (8) step();
    check("p5_pc",    dget(0).pc, 32);
    check("p5_instr", dget(0).instr, word(10'd32));
    check("p5_pc1",   dget(1).pc, 36);

    // reset with a full queue
    zero_wait();
    ready_pct = 0;
    do_reset();
    repeat (10) step();
    check("p6_full", s_count, 4);
    force_rst = 1;
    step();
    step();
    check("p6_valid", s_valid, 0);
    check("p6_count", s_count, 0);
    check("p6_req",   s_req,   0);
    force_rst = 0;
    ready_pct = 100;
    dlog.delete(); dcyc.delete();
    repeat (8) step();
    check("p6_restart_pc", dget(0).pc, 0);

    // randomized traffic
    gnt_pct = 60; ready_pct = 70; lat_lo = 1; lat_hi = 4; redir_pct = 4; rst_pm = 3;
    repeat (1500) step();
    ready_pct = 20; gnt_pct = 85; redir_pct = 6;
    repeat (1500) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the fixed 10-bit program-counter and instruction-register pair in the processor top.
- Owns the fetch PC and issues pipelined, in-order instruction reads to instruction memory over a request/grant/response handshake.
- Buffers returned words together with their PCs in a FIFO-DEPTH prefetch queue, and hands them to the control unit over a valid/ready interface.
- Supports absolute and PC-relative redirects (the add-or-set scheme), which flush the queue and discard in-flight responses.

Parameters:
ADDR_WIDTH, 10, width of PC and memory address
DATA_WIDTH, 32, instruction word width
RESET_PC, 0, fetch PC after reset
PC_STEP, 4, increment between sequential fetches
FIFO_DEPTH, 4, prefetch queue entries; power of 2, >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
mem_req  out  1  fetch request valid
mem_addr  out  ADDR_WIDTH  fetch address (= fetch_pc)
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response word valid
mem_rdata  in  DATA_WIDTH  response word
redirect_valid  in  1  redirect this cycle
redirect_add  in  1  1: target = out_pc + redirect_value; 0: target = redirect_value
redirect_value  in  ADDR_WIDTH  offset or absolute target
out_valid  out  1  queue head valid
out_instr  out  DATA_WIDTH  head instruction
out_pc  out  ADDR_WIDTH  head PC
out_ready  in  1  consumer pops head
fifo_count  out  clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset, sampled at clk edge while rst=0:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue empty, inflight=0, discard=0.
  - out_valid=0, out_instr=0, out_pc=0, fifo_count=0.
  - mem_req is forced 0 while rst=0.
- Reset mid-operation drops all in-flight state. Instruction memory is reset in the same cycle, so no stale responses are expected.
- mem_req = rst & (fifo_count + inflight < FIFO_DEPTH). inflight includes requests marked for discard. This credit rule guarantees the queue never overflows.
- A handshake completes on mem_req & mem_gnt:
  - inflight increments.
  - fetch_pc advances by PC_STEP, modulo 2^ADDR_WIDTH (wraps silently).
- Responses arrive in order, no earlier than 1 cycle after their grant. Each mem_rvalid decrements inflight.
  - If discard>0: the word is dropped and discard decrements.
  - Else: {mem_rdata, resp_pc} is pushed and resp_pc advances by PC_STEP.
- A pushed word is visible on out_* the cycle after mem_rvalid (registered queue). First fetch latency with a 0-wait memory: req/gnt in cycle 0, rvalid in cycle 1, out_valid in cycle 2.
- A pop occurs on out_valid & out_ready. Push and pop in the same cycle leaves fifo_count unchanged.
- out_* come from the queue head. out_instr/out_pc hold their last value while out_valid=0.
- Redirect, at the edge where redirect_valid=1:
  - Target is computed from the current out_pc (add mode, modulo 2^ADDR_WIDTH) or from redirect_value (set mode).
  - fetch_pc and resp_pc are set to the target; the queue is flushed (fifo_count=0, out_valid=0 next cycle).
  - discard is set to inflight after this cycle's grant and response are applied: it includes a request granted in the same cycle and excludes a response arriving in the same cycle, which is itself dropped.
  - Redirect overrides any same-cycle pop and push.
- A request that is pending but not granted when the redirect occurs is withdrawn. From the next cycle mem_addr presents the target. Memory must tolerate an address change while ungranted.
- Without redirect, mem_addr and mem_req stay stable until granted.
- A redirect in add mode while out_valid=0 uses the held out_pc.

Test Plan:
- 0-wait memory (gnt=1, rvalid 1 cycle after grant), out_ready=1 after reset release: out_pc sequence 0,4,8,12,... with first out_valid in cycle 2 and one instruction per cycle thereafter.
- out_ready=0, memory always granting: exactly 4 grants issued, fifo_count reaches 4, mem_req drops to 0; one pop re-enables exactly one request.
- PC wrap: RESET_PC=1020 with ADDR_WIDTH=10: fetched PCs are 1020, 0, 4.
- 3-cycle memory latency with 3 requests in flight, absolute redirect to 100: 3 responses dropped, the next delivered out_pc=100 with the matching word, and fifo_count=0 in the cycle after the redirect.
- Relative redirect with out_pc=40 and redirect_value=-8 (two's complement): the next out_pc is 32; a redirect coinciding with mem_rvalid and a grant drops both responses.
- rst=0 asserted mid-stream with full queue: next cycle out_valid=0, fifo_count=0, mem_req=0; after release, fetching restarts at RESET_PC.
